// File: rtl/rs_gf16_pkg.sv
// Shared GF(16) definitions for the RS(15,11) encoder and decoder chain.
//   - Field GF(16) built on the primitive polynomial x^4+x+1 (alpha = 4'h2).
//   - Generator g(x) = x^4 + G3*x^3 + G2*x^2 + G1*x + G0, roots a^1..a^4.
//   - Encoder state enum and a bit-serial GF(16) multiply.
package rs_gf16_pkg;

  localparam int SYM_W = 4;
  localparam int N     = 15;
  localparam int K     = 11;

  localparam logic [4:0] PRIM_POLY = 5'b10011;

  // Generator coefficients, polynomial basis.
  localparam logic [SYM_W-1:0] G0 = 4'd7;
  localparam logic [SYM_W-1:0] G1 = 4'd8;
  localparam logic [SYM_W-1:0] G2 = 4'd12;
  localparam logic [SYM_W-1:0] G3 = 4'd13;

  typedef enum logic {
    MSG = 1'b0,  // forwarding message symbols, LFSR absorbing them
    PAR = 1'b1   // draining the four parity symbols
  } enc_state_e;

  // Shift-and-add multiply: walk the bits of b, doubling a (times alpha)
  // each step and folding x^4 back with the primitive polynomial.
  function automatic logic [SYM_W-1:0] gf16_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] acc;
    logic [SYM_W-1:0] aa;
    acc = '0;
    aa  = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[SYM_W-2:0], 1'b0} ^ (aa[SYM_W-1] ? PRIM_POLY[SYM_W-1:0] : '0);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf16_const_mul.sv
// Multiply a GF(16) symbol by a fixed constant C. With C constant the
// function collapses to a small XOR network.
//   a_i  in  SYM_W  multiplicand
//   p_o  out SYM_W  a_i * C in GF(16)
module gf16_const_mul
  import rs_gf16_pkg::*;
#(
  parameter logic [SYM_W-1:0] C = '0
) (
  input  logic [SYM_W-1:0] a_i,
  output logic [SYM_W-1:0] p_o
);

  assign p_o = gf16_mul(a_i, C);

endmodule

// File: rtl/rs_15_11_encoder.sv
// Systematic RS(15,11) encoder over GF(16).
// Takes 11 message symbols (m10 first), forwards each one through a single
// output register, then appends the 4 parity symbols held in the LFSR.
// Ports:
//   CLK         in   1      rising-edge clock
//   RESET       in   1      asynchronous active-low reset
//   DATA_IN     in   SYM_W  message symbol
//   IN_VALID    in   1      DATA_IN valid
//   IN_READY    out  1      encoder accepts DATA_IN this cycle
//   DATA_OUT    out  SYM_W  codeword symbol, c14 first
//   OUT_VALID   out  1      DATA_OUT valid
//   OUT_READY   in   1      sink accepts DATA_OUT
//   OUT_LAST    out  1      marks c0
//   OUT_PARITY  out  1      marks the four parity symbols
module rs_15_11_encoder #(
  parameter int N     = rs_gf16_pkg::N,
  parameter int K     = rs_gf16_pkg::K,
  parameter int SYM_W = rs_gf16_pkg::SYM_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [SYM_W-1:0] DATA_IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [SYM_W-1:0] DATA_OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             OUT_LAST,
  output logic             OUT_PARITY
);

  import rs_gf16_pkg::*;

  localparam logic [3:0] SYM_LAST = 4'(K - 1);
  localparam logic [1:0] PAR_LAST = 2'(N - K - 1);

  enc_state_e              state_q, state_d;
  logic [3:0]              sym_cnt_q, sym_cnt_d;
  logic [1:0]              par_cnt_q, par_cnt_d;
  logic [3:0][SYM_W-1:0]   lfsr_q, lfsr_d;     // [3] = r3 (next parity out)
  logic [SYM_W-1:0]        data_out_q, data_out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    out_parity_q, out_parity_d;

  logic                    slot_free;
  logic                    in_accept;
  logic [SYM_W-1:0]        fb;
  logic [SYM_W-1:0]        fb_g0, fb_g1, fb_g2, fb_g3;

  // The output register can take a new symbol when empty or being drained.
  assign slot_free = !out_valid_q || OUT_READY;
  assign IN_READY  = (state_q == MSG) && slot_free;
  assign in_accept = IN_VALID && IN_READY;

  assign fb = DATA_IN ^ lfsr_q[3];

  gf16_const_mul #(.C(G0)) u_mul_g0 (.a_i(fb), .p_o(fb_g0));
  gf16_const_mul #(.C(G1)) u_mul_g1 (.a_i(fb), .p_o(fb_g1));
  gf16_const_mul #(.C(G2)) u_mul_g2 (.a_i(fb), .p_o(fb_g2));
  gf16_const_mul #(.C(G3)) u_mul_g3 (.a_i(fb), .p_o(fb_g3));

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    sym_cnt_d    = sym_cnt_q;
    par_cnt_d    = par_cnt_q;
    lfsr_d       = lfsr_q;
    data_out_d   = data_out_q;
    out_valid_d  = out_valid_q && !OUT_READY;  // drained unless refilled below
    out_last_d   = out_last_q;
    out_parity_d = out_parity_q;

    unique case (state_q)
      MSG: begin
        if (in_accept) begin
          data_out_d   = DATA_IN;
          out_valid_d  = 1'b1;
          out_last_d   = 1'b0;
          out_parity_d = 1'b0;
          lfsr_d       = {lfsr_q[2] ^ fb_g3, lfsr_q[1] ^ fb_g2,
                          lfsr_q[0] ^ fb_g1, fb_g0};
          if (sym_cnt_q == SYM_LAST) begin
            state_d   = PAR;
            sym_cnt_d = '0;
            par_cnt_d = '0;
          end else begin
            sym_cnt_d = sym_cnt_q + 4'd1;
          end
        end
      end
      PAR: begin
        if (slot_free) begin
          data_out_d   = lfsr_q[3];
          lfsr_d       = {lfsr_q[2:0], {SYM_W{1'b0}}};  // leaves LFSR zero after 4 shifts
          out_valid_d  = 1'b1;
          out_parity_d = 1'b1;
          out_last_d   = (par_cnt_q == PAR_LAST);
          if (par_cnt_q == PAR_LAST) begin
            state_d   = MSG;
            sym_cnt_d = '0;
            par_cnt_d = '0;
          end else begin
            par_cnt_d = par_cnt_q + 2'd1;
          end
        end
      end
      default: state_d = MSG;
    endcase
  end

  // NOTE: the LFSR is a handful of flops, not a memory, and must start each frame at zero, so it is reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= MSG;
      sym_cnt_q    <= '0;
      par_cnt_q    <= '0;
      lfsr_q       <= '0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_parity_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      par_cnt_q    <= par_cnt_d;
      lfsr_q       <= lfsr_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_parity_q <= out_parity_d;
    end
  end

  assign DATA_OUT   = data_out_q;
  assign OUT_VALID  = out_valid_q;
  assign OUT_LAST   = out_last_q;
  assign OUT_PARITY = out_parity_q;

endmodule

// File: tb/tb_rs_15_11_encoder.sv
// Directed bench for rs_15_11_encoder: known parity vectors, syndrome checks
// on random frames under back-pressure, back-to-back framing and mid-frame reset.
module tb_rs_15_11_encoder;

  logic       CLK;
  logic       RESET;
  logic [3:0] DATA_IN;
  logic       IN_VALID;
  logic       IN_READY;
  logic [3:0] DATA_OUT;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic       OUT_LAST;
  logic       OUT_PARITY;

  int test_cnt = 0;
  int fail_cnt = 0;

  logic [3:0] msg_a [11];
  logic [3:0] cw_a  [15];
  logic [3:0] msg2  [22];
  logic [3:0] cw2   [30];

  rs_15_11_encoder dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .DATA_IN   (DATA_IN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .DATA_OUT  (DATA_OUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_LAST  (OUT_LAST),
    .OUT_PARITY(OUT_PARITY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Schoolbook product then reduction of degrees 6..4 by x^4+x+1.
  function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ ({4'b0, a} << i);
    for (int d = 6; d >= 4; d--)
      if (p[d]) p = p ^ (8'b0001_0011 << (d - 4));
    return p[3:0];
  endfunction

  // Feed msg_a, collect 15 symbols into cw_a. Optional random gaps on
  // IN_VALID and random back-pressure on OUT_READY.
  task automatic run_frame(input string tag, input bit rand_ready, input bit rand_valid);
    int  in_idx = 0;
    int  out_idx = 0;
    int  cycles = 0;
    bit  prev_stall = 0;
    logic [3:0] prev_data = '0;
    while (out_idx < 15 && cycles < 2000) begin
      @(negedge CLK);
      IN_VALID  = (in_idx < 11) && (!rand_valid || ($urandom_range(1, 0) == 1));
      DATA_IN   = (in_idx < 11) ? msg_a[in_idx] : 4'h0;
      OUT_READY = !rand_ready || ($urandom_range(1, 0) == 1);
      #1;
      if (prev_stall) begin
        check({tag, "_stall_valid"}, int'(OUT_VALID), 1);
        check({tag, "_stall_data"}, int'(DATA_OUT), int'(prev_data));
      end
      prev_stall = OUT_VALID && !OUT_READY;
      prev_data  = DATA_OUT;
      if (IN_VALID && IN_READY) in_idx++;
      if (OUT_VALID && OUT_READY) begin
        cw_a[out_idx] = DATA_OUT;
        check({tag, "_parity_flag"}, int'(OUT_PARITY), int'(out_idx >= 11));
        check({tag, "_last_flag"}, int'(OUT_LAST), int'(out_idx == 14));
        out_idx++;
      end
      cycles++;
    end
    check({tag, "_symbol_count"}, out_idx, 15);
    @(negedge CLK);
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    #1;
    check({tag, "_no_extra"}, int'(OUT_VALID), 0);
    for (int i = 0; i < 11; i++)
      check({tag, "_systematic"}, int'(cw_a[i]), int'(msg_a[i]));
  endtask

  task automatic check_parity(input string tag, input int p3, input int p2,
                              input int p1, input int p0);
    check({tag, "_c3"}, int'(cw_a[11]), p3);
    check({tag, "_c2"}, int'(cw_a[12]), p2);
    check({tag, "_c1"}, int'(cw_a[13]), p1);
    check({tag, "_c0"}, int'(cw_a[14]), p0);
  endtask

  task automatic check_syndromes(input string tag);
    logic [3:0] root;
    logic [3:0] s;
    root = 4'h2;  // a^1
    for (int j = 1; j <= 4; j++) begin
      s = '0;
      for (int i = 0; i < 15; i++) s = ref_mul(s, root) ^ cw_a[i];
      check($sformatf("%s_S%0d", tag, j), int'(s), 0);
      root = ref_mul(root, 4'h2);
    end
  endtask

  task automatic set_unit_msg(input logic [3:0] last_sym);
    for (int i = 0; i < 10; i++) msg_a[i] = 4'h0;
    msg_a[10] = last_sym;
  endtask

  initial begin
    RESET     = 1'b0;
    IN_VALID  = 1'b0;
    DATA_IN   = 4'h0;
    OUT_READY = 1'b0;
    #12;
    // Reset state
    check("rst_out_valid", int'(OUT_VALID), 0);
    check("rst_data_out", int'(DATA_OUT), 0);
    check("rst_last", int'(OUT_LAST), 0);
    check("rst_parity", int'(OUT_PARITY), 0);
    check("rst_in_ready", int'(IN_READY), 1);
    @(negedge CLK);
    RESET = 1'b1;

    // 1: all-zero message
    set_unit_msg(4'h0);
    run_frame("t1", 1'b0, 1'b0);
    check_parity("t1", 0, 0, 0, 0);

    // 2: unit message -> generator coefficients as parity
    set_unit_msg(4'h1);
    run_frame("t2", 1'b0, 1'b0);
    check_parity("t2", 13, 12, 8, 7);

    // 3: scaled by alpha -> parity scales by alpha
    set_unit_msg(4'h2);
    run_frame("t3", 1'b0, 1'b0);
    check_parity("t3", 9, 11, 3, 14);

    // 4: random frames, random gaps and back-pressure
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 11; i++) msg_a[i] = 4'($urandom_range(15, 0));
      run_frame($sformatf("t4f%0d", f), 1'b1, 1'b1);
      check_syndromes($sformatf("t4f%0d", f));
    end

    // 5: two frames back-to-back, no gaps
    begin
      int in_idx = 0;
      int outs = 0;
      int gaps = 0;
      int low = 0;
      bit started = 0;
      for (int i = 0; i < 22; i++) msg2[i] = 4'h0;
      msg2[10] = 4'h1;
      msg2[21] = 4'h2;
      for (int c = 0; c < 80 && outs < 30; c++) begin
        @(negedge CLK);
        IN_VALID  = (in_idx < 22);
        DATA_IN   = (in_idx < 22) ? msg2[in_idx] : 4'h0;
        OUT_READY = 1'b1;
        #1;
        if (!IN_READY) low++;
        if (OUT_VALID) begin
          started = 1;
          cw2[outs] = DATA_OUT;
          outs++;
        end else if (started) begin
          gaps++;
        end
        if (IN_VALID && IN_READY) in_idx++;
      end
      IN_VALID = 1'b0;
      check("t5_outputs", outs, 30);
      check("t5_gaps", gaps, 0);
      check("t5_in_ready_low", low, 8);
      check("t5_f1_c3", int'(cw2[11]), 13);
      check("t5_f1_c0", int'(cw2[14]), 7);
      check("t5_f2_m0", int'(cw2[25]), 2);
      check("t5_f2_c3", int'(cw2[26]), 9);
      check("t5_f2_c2", int'(cw2[27]), 11);
      check("t5_f2_c1", int'(cw2[28]), 3);
      check("t5_f2_c0", int'(cw2[29]), 14);
    end

    // 6: reset after 6 message symbols, then a clean frame
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      IN_VALID  = 1'b1;
      DATA_IN   = 4'(i + 5);
      OUT_READY = 1'b1;
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    RESET    = 1'b0;
    #1;
    check("t6_rst_valid", int'(OUT_VALID), 0);
    check("t6_rst_data", int'(DATA_OUT), 0);
    check("t6_rst_last", int'(OUT_LAST), 0);
    check("t6_rst_parity", int'(OUT_PARITY), 0);
    check("t6_rst_in_ready", int'(IN_READY), 1);
    @(negedge CLK);
    RESET = 1'b1;
    set_unit_msg(4'h1);
    run_frame("t6", 1'b0, 1'b0);
    check_parity("t6", 13, 12, 8, 7);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
